// File: rtl/regfile_pkg.sv
// Shared register-file writeback constants and the writeback sequencer state type.
package regfile_pkg;
    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;
    localparam int IDX_W    = $clog2(NUM_REGS);

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } wb_state_t;
endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-input round-robin grant; combinational grant, last_grant moves only on a grant.
// When both are valid the requester that did not win last time is granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11)
                grant = last_grant ? 2'b01 : 2'b10;
            else
                grant = valid;
        end
    end

    // A grant is always an accept, because ready is the grant itself.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (grant != 2'b00)
            last_grant <= grant[1];
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port owner: zero-fill walk after reset/clear_req, then round-robin writeback.
// Accept-to-write latency 1 cycle; readies are low during the walk and in the clear_req cycle.
// Build option X0_WRITE_FILTER_EN: accepted writes to rd 0 are dropped (walk still clears x0).
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_req,
    input  logic             req0_valid,
    input  logic [IDX_W-1:0] req0_rd,
    input  logic [XLEN-1:0]  req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [IDX_W-1:0] req1_rd,
    input  logic [XLEN-1:0]  req1_data,
    output logic             req1_ready,
    output logic             RegWrite,
    output logic [IDX_W-1:0] RD,
    output logic [XLEN-1:0]  WriteData,
    output logic             busy
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    wb_state_t        state, state_next;
    logic [IDX_W-1:0] clr_idx;
    logic [1:0]       grant;
    logic             arb_en;
    logic             accept;
    logic             wr_en;
    logic [IDX_W-1:0] win_rd;
    logic [XLEN-1:0]  win_data;

    assign arb_en = (state == ARB) && !clear_req;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .valid  ({req1_valid, req0_valid}),
        .enable (arb_en),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = grant[0] | grant[1];
    assign win_rd     = grant[1] ? req1_rd   : req0_rd;
    assign win_data   = grant[1] ? req1_data : req0_data;

`ifdef X0_WRITE_FILTER_EN
    assign wr_en = accept && (win_rd != '0);
`else
    assign wr_en = accept;
`endif

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_idx == LAST_IDX) state_next = ARB;
            ARB:     if (clear_req)           state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= CLEAR;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_idx   <= '0;
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
            busy      <= 1'b1;
        end else if (state == CLEAR) begin
            RegWrite  <= 1'b1;
            RD        <= clr_idx;
            WriteData <= '0;
            clr_idx   <= clr_idx + 1'b1;
            busy      <= (clr_idx != LAST_IDX);
        end else begin
            // clear_req blocks the arbiter, so wr_en is already low on that edge.
            clr_idx  <= '0;
            busy     <= clear_req;
            RegWrite <= wr_en;
            if (wr_en) begin
                RD        <= win_rd;
                WriteData <= win_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a behavioural model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

`ifdef X0_WRITE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, clear_req;
    logic             req0_valid, req1_valid;
    logic [IDX_W-1:0] req0_rd, req1_rd;
    logic [XLEN-1:0]  req0_data, req1_data;
    logic             req0_ready, req1_ready;
    logic             RegWrite, busy;
    logic [IDX_W-1:0] RD;
    logic [XLEN-1:0]  WriteData;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    bit          m_clearing;
    int          m_idx;
    int          m_last;
    bit          m_we, m_busy;
    int          m_rd;
    logic [63:0] m_wd;

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        if (m_clearing || clear_req) return -1;
        if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        g = model_grant();
        if (reset) begin
            m_clearing = 1; m_idx = 0; m_last = 1;
            m_we = 0; m_rd = 0; m_wd = 0; m_busy = 1;
        end else if (m_clearing) begin
            m_we = 1; m_rd = m_idx; m_wd = 0;
            if (m_idx == NUM_REGS - 1) begin
                m_clearing = 0; m_busy = 0;
            end
            m_idx++;
        end else if (clear_req) begin
            m_clearing = 1; m_idx = 0; m_busy = 1; m_we = 0;
        end else if (g >= 0) begin
            int    rd;
            logic [63:0] d;
            rd = (g == 1) ? int'(req1_rd) : int'(req0_rd);
            d  = (g == 1) ? req1_data : req0_data;
            m_last = g;
            m_we = !(FILT && rd == 0);
            if (m_we) begin
                m_rd = rd; m_wd = d;
            end
        end else begin
            m_we = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        clear_req = 0; req0_valid = 0; req1_valid = 0;
        req0_rd = 0; req1_rd = 0; req0_data = 0; req1_data = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        tick(); tick();
        n_checks++;
        if (RegWrite !== 1'b0 || RD !== '0 || WriteData !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: we=%b rd=%0d wd=%h busy=%b, want we=0 rd=0 wd=0 busy=1",
                     RegWrite, RD, WriteData, busy);
        end
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: r0=%b r1=%b, want 0 0", req0_ready, req1_ready);
        end
    endtask

    task automatic test_clear_walk();
        reset = 0;
        req0_valid = 1; req0_rd = 3; req0_data = 64'h11;
        req1_valid = 1; req1_rd = 4; req1_data = 64'h22;
        for (int i = 0; i < NUM_REGS; i++) begin
            clear_req = (i == 5);
            #3;
            n_checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL walk_ready[%0d]: r0=%b r1=%b, want 0 0", i, req0_ready, req1_ready);
            end
            tick();
            #1;
            if (i == NUM_REGS - 1) begin
                req0_valid = 0; req1_valid = 0;
            end
            clear_req = 0;
            n_checks++;
            if (RegWrite !== 1'b1 || int'(RD) != i || WriteData !== '0 || busy !== (i != NUM_REGS - 1)) begin
                n_fail++;
                $display("FAIL walk_write[%0d]: we=%b rd=%0d wd=%h busy=%b, want we=1 rd=%0d wd=0 busy=%b",
                         i, RegWrite, RD, WriteData, busy, i, (i != NUM_REGS - 1));
            end
        end
    endtask

    task automatic test_single();
        req0_valid = 1; req0_rd = 8; req0_data = 64'd22;
        #2;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0;
        n_checks++;
        if (RegWrite !== 1'b1 || RD !== 5'd8 || WriteData !== 64'd22) begin
            n_fail++;
            $display("FAIL single_write: we=%b rd=%0d wd=%0d, want 1 8 22", RegWrite, RD, WriteData);
        end
        tick();
        n_checks++;
        if (RegWrite !== 1'b0 || RD !== 5'd8 || WriteData !== 64'd22) begin
            n_fail++;
            $display("FAIL idle_hold: we=%b rd=%0d wd=%0d, want 0 8 22", RegWrite, RD, WriteData);
        end
    endtask

    task automatic test_alternate();
        int prev;
        prev = -1;
        req0_valid = 1; req0_rd = 9;  req0_data = 64'd21;
        req1_valid = 1; req1_rd = 10; req1_data = 64'd22;
        for (int i = 0; i < 4; i++) begin
            int g;
            #2;
            g = model_grant();
            n_checks++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1) || g == prev) begin
                n_fail++;
                $display("FAIL alt_grant[%0d]: r0=%b r1=%b, want grant %0d (prev %0d)",
                         i, req0_ready, req1_ready, g, prev);
            end
            prev = g;
            tick();
            n_checks++;
            if (RegWrite !== 1'b1 || int'(RD) != (g == 0 ? 9 : 10) || WriteData !== (g == 0 ? 64'd21 : 64'd22)) begin
                n_fail++;
                $display("FAIL alt_write[%0d]: we=%b rd=%0d wd=%0d, want rd %0d", i, RegWrite, RD, WriteData,
                         (g == 0 ? 9 : 10));
            end
        end
        req0_valid = 0;
    endtask

    task automatic test_clear_req();
        req1_valid = 1; req1_rd = 12; req1_data = 64'd77;
        clear_req = 1;
        #2;
        n_checks++;
        if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clrreq_ready: r0=%b r1=%b, want 0 0", req0_ready, req1_ready);
        end
        tick();
        clear_req = 0;
        n_checks++;
        if (busy !== 1'b1 || RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL clrreq_busy: busy=%b we=%b, want 1 0", busy, RegWrite);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            n_checks++;
            if (req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL clrreq_walk_ready[%0d]: r1=%b, want 0", i, req1_ready);
            end
            tick();
            n_checks++;
            if (RegWrite !== 1'b1 || int'(RD) != i || WriteData !== '0) begin
                n_fail++;
                $display("FAIL clrreq_walk[%0d]: we=%b rd=%0d wd=%h, want 1 %0d 0", i, RegWrite, RD, WriteData, i);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clrreq_resume: busy=%b r1=%b, want 0 1", busy, req1_ready);
        end
        tick();
        req1_valid = 0;
        n_checks++;
        if (RegWrite !== 1'b1 || RD !== 5'd12 || WriteData !== 64'd77) begin
            n_fail++;
            $display("FAIL clrreq_after: we=%b rd=%0d wd=%0d, want 1 12 77", RegWrite, RD, WriteData);
        end
    endtask

    task automatic test_reset_midwalk();
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 17; i++) tick();
        // last write shown is RD=16, the walk is about to issue 17
        reset = 1; tick(); reset = 0;
        n_checks++;
        if (RegWrite !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_state: we=%b busy=%b, want 0 1", RegWrite, busy);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            tick();
            n_checks++;
            if (RegWrite !== 1'b1 || int'(RD) != i) begin
                n_fail++;
                $display("FAIL midreset_walk[%0d]: we=%b rd=%0d, want 1 %0d", i, RegWrite, RD, i);
            end
        end
    endtask

    task automatic test_x0();
        req0_valid = 1; req0_rd = 0; req0_data = 64'd5;
        #2;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_ready: r0=%b, want 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        n_checks++;
        if (FILT ? (RegWrite !== 1'b0)
                 : (RegWrite !== 1'b1 || RD !== '0 || WriteData !== 64'd5)) begin
            n_fail++;
            $display("FAIL x0_write: we=%b rd=%0d wd=%0d, filter=%0d", RegWrite, RD, WriteData, FILT);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int g;
            reset      = ($urandom_range(0, 199) == 0);
            clear_req  = ($urandom_range(0, 39) == 0);
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            req0_rd    = IDX_W'($urandom_range(0, 3));
            req1_rd    = IDX_W'($urandom_range(0, 3));
            req0_data  = {$urandom, $urandom};
            req1_data  = {$urandom, $urandom};
            #2;
            g = model_grant();
            n_checks++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: r0=%b r1=%b, want grant %0d", i, req0_ready, req1_ready, g);
            end
            tick();
            n_checks++;
            if (RegWrite !== m_we || int'(RD) != m_rd || WriteData !== m_wd || busy !== m_busy) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: we=%b rd=%0d wd=%h busy=%b, want %b %0d %h %b",
                         i, RegWrite, RD, WriteData, busy, m_we, m_rd, m_wd, m_busy);
            end
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        m_clearing = 1; m_idx = 0; m_last = 1; m_we = 0; m_rd = 0; m_wd = 0; m_busy = 1;
        test_reset();
        test_clear_walk();
        test_single();
        test_alternate();
        test_clear_req();
        test_reset_midwalk();
        test_x0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
